seq_control_fsm: RTL and testbench

Multi-cycle control sequencer for the sequential processing unit. It steps each instruction through fetch, decode, execute, memory and write-back using the instruction decoder's type and op-class outputs, and drives the datapath's PC, register-file, ALU-operand and memory handshake controls. It also counts retired instructions and halts on SYSCALL or an illegal op class.

---
 rtl/seq_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_seq_control_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_fsm.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath PC, register-file, ALU-operand and memory handshake controls, counts retirements.
module seq_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       final_type,
  input  logic [2:0]       op_type,
  input  logic [5:0]       opc,
  input  logic [5:0]       funct,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_dst_sel,
  output logic [1:0]       rf_wd_sel,
  output logic             alu_b_imm,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [1:0] T_I = 2'b00;
  localparam logic [1:0] T_R = 2'b01;

  localparam logic [2:0] C_PC  = 3'b010;
  localparam logic [2:0] C_MEM = 3'b011;
  localparam logic [2:0] C_SYS = 3'b110;
  localparam logic [2:0] C_ILL = 3'b111;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  logic [2:0]       state_reg, state_next;
  logic [1:0]       ftype_reg;
  logic [2:0]       opclass_reg;
  logic [5:0]       opc_reg;
  logic [5:0]       funct_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      ftype_reg   <= '0;
      opclass_reg <= '0;
      opc_reg     <= '0;
      funct_reg   <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      // Decoder outputs are only trusted in DECODE; later states read these copies.
      if (state_reg == DECODE) begin
        ftype_reg   <= final_type;
        opclass_reg <= op_type;
        opc_reg     <= opc;
        funct_reg   <= funct;
      end
      if (pc_load) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = PC_SEQ;
    rf_we      = 1'b0;
    rf_dst_sel = DST_RT;
    rf_wd_sel  = WD_ALU;
    alu_b_imm  = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = (op_type == C_SYS || op_type == C_ILL) ? HALT : EXEC;
      end
      EXEC: begin
        alu_b_imm = (ftype_reg == T_I);
        case (opclass_reg)
          C_MEM: state_next = MEM;
          C_PC: begin
            pc_load    = 1'b1;
            state_next = FETCH;
            if (opc_reg == OPC_J) begin
              pc_sel = PC_JMP;
            end else if (opc_reg == OPC_JAL) begin
              pc_sel     = PC_JMP;
              rf_we      = 1'b1;
              rf_dst_sel = DST_R31;
              rf_wd_sel  = WD_PC4;
            end else if (ftype_reg == T_R && funct_reg == FN_JR) begin
              pc_sel = PC_REG;
            end else if (ftype_reg == T_R && funct_reg == FN_JALR) begin
              pc_sel     = PC_REG;
              rf_we      = 1'b1;
              rf_dst_sel = DST_RD;
              rf_wd_sel  = WD_PC4;
            end else begin
              pc_sel = branch_taken ? PC_BR : PC_SEQ;
            end
          end
          default: state_next = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc_reg == OPC_SW);
        if (dmem_ready) begin
          if (opc_reg == OPC_SW) begin
            pc_load    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        pc_load    = 1'b1;
        rf_dst_sel = (ftype_reg == T_R) ? DST_RD : DST_RT;
        rf_wd_sel  = (opclass_reg == C_MEM) ? WD_MEM : WD_ALU;
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = HALT;
    endcase
  end

  assign state       = state_reg;
  assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_control_fsm.sv
// Directed bench for seq_control_fsm: expected control vectors are queued as each cycle's
// stimulus is driven and compared when that cycle's outputs are sampled on the falling edge.
module tb_seq_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] final_type;
  logic [2:0] op_type;
  logic [5:0] opc;
  logic [5:0] funct;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_ready;

  logic        a_imem_req, a_ir_load, a_dmem_req, a_dmem_we, a_pc_load, a_rf_we, a_alu_b_imm, a_halted;
  logic [1:0]  a_pc_sel, a_rf_dst_sel, a_rf_wd_sel;
  logic [2:0]  a_state;
  logic [31:0] a_cnt;

  logic        w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_pc_load, w_rf_we, w_alu_b_imm, w_halted;
  logic [1:0]  w_pc_sel, w_rf_dst_sel, w_rf_wd_sel;
  logic [2:0]  w_state;
  logic [2:0]  w_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .final_type(final_type), .op_type(op_type), .opc(opc),
    .funct(funct), .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(a_imem_req), .ir_load(a_ir_load), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
    .pc_load(a_pc_load), .pc_sel(a_pc_sel), .rf_we(a_rf_we), .rf_dst_sel(a_rf_dst_sel),
    .rf_wd_sel(a_rf_wd_sel), .alu_b_imm(a_alu_b_imm), .state(a_state), .halted(a_halted),
    .retired_cnt(a_cnt)
  );

  // Narrow counter instance to exercise the all-ones -> zero wrap in a few retirements.
  seq_control_fsm #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .final_type(final_type), .op_type(op_type), .opc(opc),
    .funct(funct), .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(w_imem_req), .ir_load(w_ir_load), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .pc_load(w_pc_load), .pc_sel(w_pc_sel), .rf_we(w_rf_we), .rf_dst_sel(w_rf_dst_sel),
    .rf_wd_sel(w_rf_wd_sel), .alu_b_imm(w_alu_b_imm), .state(w_state), .halted(w_halted),
    .retired_cnt(w_cnt)
  );

  wire [16:0] obs_a = {a_state, a_halted, a_imem_req, a_ir_load, a_dmem_req, a_dmem_we,
                       a_pc_load, a_pc_sel, a_rf_we, a_rf_dst_sel, a_rf_wd_sel, a_alu_b_imm};
  wire [16:0] obs_w = {w_state, w_halted, w_imem_req, w_ir_load, w_dmem_req, w_dmem_we,
                       w_pc_load, w_pc_sel, w_rf_we, w_rf_dst_sel, w_rf_wd_sel, w_alu_b_imm};

  // {state, halted, imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel, rf_we, rf_dst_sel, rf_wd_sel, alu_b_imm}
  function automatic logic [16:0] ev(logic [2:0] st, logic hl, logic im, logic ir, logic dr, logic dw,
                                     logic pl, logic [1:0] ps, logic we, logic [1:0] ds,
                                     logic [1:0] ws, logic bi);
    return {st, hl, im, ir, dr, dw, pl, ps, we, ds, ws, bi};
  endfunction

  function automatic logic [16:0] f_wait();
    return ev(3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [16:0] f_go();
    return ev(3'd0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [16:0] f_dec();
    return ev(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [16:0] f_halt();
    return ev(3'd5, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
  endfunction

  task automatic compare(input string tag, input logic [16:0] exp_v);
    vectors++;
    assert (obs_a === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs_a, exp_v);
    end
    vectors++;
    assert (obs_w === exp_v) else begin
      miscompares++;
      $error("FAIL %s_narrow: observed %h expected %h", tag, obs_w, exp_v);
    end
  endtask

  // One clock cycle: inputs already driven; queue expectation, check at negedge, advance.
  task automatic cyc(input string tag, input logic [16:0] exp_v);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.v   = exp_v;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    compare(got.tag, got.v);
    $display("cycle %s state=%0d ctl=%h cnt=%0d", got.tag, a_state, obs_a, a_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp_a, input logic [2:0] exp_w);
    vectors++;
    assert (a_cnt === exp_a) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, a_cnt, exp_a);
    end
    vectors++;
    assert (w_cnt === exp_w) else begin
      miscompares++;
      $error("FAIL %s_narrow: observed %0d expected %0d", tag, w_cnt, exp_w);
    end
  endtask

  task automatic set_instr(input logic [1:0] ft, input logic [2:0] ot, input logic [5:0] oc,
                           input logic [5:0] fn);
    final_type = ft;
    op_type    = ot;
    opc        = oc;
    funct      = fn;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    set_instr(2'b00, 3'b000, 6'd0, 6'd0);
    #2;
    cyc("reset", f_wait());
    chk_cnt("reset_cnt", 32'd0, 3'd0);
    rst_n = 1'b1;

    // ADD: R type, 4 cycles; a stray dmem_ready in DECODE must be ignored
    set_instr(2'b01, 3'b000, 6'b000000, 6'b100000);
    imem_ready = 1'b1;
    cyc("add_fetch", f_go());
    imem_ready = 1'b0; dmem_ready = 1'b1;
    cyc("add_dec", f_dec());
    dmem_ready = 1'b0;
    cyc("add_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    cyc("add_wb", ev(3'd4, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 2'b00, 0));
    chk_cnt("add_cnt", 32'd1, 3'd1);

    // LW with one imem wait and two dmem wait cycles
    set_instr(2'b00, 3'b011, 6'b100011, 6'd0);
    cyc("lw_fwait", f_wait());
    imem_ready = 1'b1;
    cyc("lw_fetch", f_go());
    imem_ready = 1'b0;
    cyc("lw_dec", f_dec());
    cyc("lw_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
    cyc("lw_mem0", ev(3'd3, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    cyc("lw_mem1", ev(3'd3, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    dmem_ready = 1'b1;
    cyc("lw_mem2", ev(3'd3, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    dmem_ready = 1'b0;
    cyc("lw_wb", ev(3'd4, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 2'b01, 0));
    chk_cnt("lw_cnt", 32'd2, 3'd2);

    // BEQ taken then not taken
    for (int t = 1; t >= 0; t--) begin
      set_instr(2'b00, 3'b010, 6'b000100, 6'd0);
      imem_ready = 1'b1;
      cyc("beq_fetch", f_go());
      imem_ready = 1'b0;
      branch_taken = ~t[0];
      cyc("beq_dec", f_dec());
      branch_taken = t[0];
      cyc(t == 1 ? "beq_taken" : "beq_not_taken",
          ev(3'd2, 0, 0, 0, 0, 0, 1, t == 1 ? 2'b01 : 2'b00, 0, 2'b00, 2'b00, 1));
      branch_taken = 1'b0;
    end
    chk_cnt("beq_cnt", 32'd4, 3'd4);

    // JAL
    set_instr(2'b10, 3'b010, 6'b000011, 6'd0);
    imem_ready = 1'b1;
    cyc("jal_fetch", f_go());
    imem_ready = 1'b0;
    cyc("jal_dec", f_dec());
    cyc("jal_exec", ev(3'd2, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 0));

    // JALR
    set_instr(2'b01, 3'b010, 6'b000000, 6'b001001);
    imem_ready = 1'b1;
    cyc("jalr_fetch", f_go());
    imem_ready = 1'b0;
    cyc("jalr_dec", f_dec());
    cyc("jalr_exec", ev(3'd2, 0, 0, 0, 0, 0, 1, 2'b11, 1, 2'b01, 2'b10, 0));
    chk_cnt("jalr_cnt", 32'd6, 3'd6);

    // SW zero-wait: 4 cycles, retires in MEM
    set_instr(2'b00, 3'b011, 6'b101011, 6'd0);
    imem_ready = 1'b1;
    cyc("sw_fetch", f_go());
    imem_ready = 1'b0;
    cyc("sw_dec", f_dec());
    cyc("sw_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
    dmem_ready = 1'b1;
    cyc("sw_mem", ev(3'd3, 0, 0, 0, 1, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0));
    dmem_ready = 1'b0;
    chk_cnt("sw_cnt", 32'd7, 3'd7);

    // ADDI; decoder inputs change after DECODE and must not affect EXEC/WB
    set_instr(2'b00, 3'b000, 6'b001000, 6'd0);
    imem_ready = 1'b1;
    cyc("addi_fetch", f_go());
    imem_ready = 1'b0;
    cyc("addi_dec", f_dec());
    set_instr(2'b01, 3'b011, 6'b100011, 6'b001000);
    cyc("addi_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
    cyc("addi_wb", ev(3'd4, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0));
    chk_cnt("wrap_cnt", 32'd8, 3'd0);

    // SYSCALL halts; 20 idle cycles with ready inputs toggling
    set_instr(2'b00, 3'b110, 6'd0, 6'b001100);
    imem_ready = 1'b1;
    cyc("sys_fetch", f_go());
    cyc("sys_dec", f_dec());
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      dmem_ready = ~i[0];
      cyc("halt_idle", f_halt());
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    chk_cnt("halt_cnt", 32'd8, 3'd0);

    // Reset out of HALT, then SW stalled in MEM aborted by reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_instr(2'b00, 3'b011, 6'b101011, 6'd0);
    imem_ready = 1'b1;
    cyc("sw2_fetch", f_go());
    imem_ready = 1'b0;
    cyc("sw2_dec", f_dec());
    cyc("sw2_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
    cyc("sw2_mem", ev(3'd3, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0));
    #1;
    rst_n = 1'b0;
    #1;
    compare("abort_async", f_wait());
    chk_cnt("abort_cnt", 32'd0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("after_reset", f_wait());
    chk_cnt("after_reset_cnt", 32'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
